// File: rtl/adc_responder_if.sv
// Handshake bundle between a sample consumer (master) and the converter
// model (slave): soc/ain toward the converter, eoc/x/nconv/err back.
interface adc_responder_if #(
    parameter int W = 8
);
    logic         soc;
    logic [W-1:0] ain;
    logic         eoc;
    logic [W-1:0] x;
    logic [15:0]  nconv;
    logic         err;

    modport master (
        output soc,
        output ain,
        input  eoc,
        input  x,
        input  nconv,
        input  err
    );

    modport slave (
        input  soc,
        input  ain,
        output eoc,
        output x,
        output nconv,
        output err
    );
endinterface

// File: rtl/adc_responder.sv
// Converter side of the soc/eoc handshake: captures ain on soc, stays busy
// for the acknowledge phase plus CONV_CYCLES edges, then publishes the sample.
module adc_responder #(
    parameter int CONV_CYCLES = 4,
    parameter int W           = 8
) (
    input  logic            clock,
    input  logic            reset,
    adc_responder_if.slave  bus
);
    localparam logic [1:0] READY = 2'd0;
    localparam logic [1:0] ACK   = 2'd1;
    localparam logic [1:0] CONV  = 2'd2;

    localparam logic [7:0] CNT_LOAD = 8'(CONV_CYCLES - 1);

    logic [1:0]   state;
    logic [7:0]   cnt;
    logic [W-1:0] hold;
    logic [W-1:0] x_r;
    logic [15:0]  nconv_r;
    logic         err_r;

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= READY;
            cnt     <= 8'd0;
            hold    <= '0;
            x_r     <= '0;
            nconv_r <= 16'd0;
            err_r   <= 1'b0;
        end else begin
            case (state)
                READY: begin
                    if (bus.soc) begin
                        hold  <= bus.ain;
                        state <= ACK;
                    end
                end
                ACK: begin
                    if (!bus.soc) begin
                        cnt   <= CNT_LOAD;
                        state <= CONV;
                    end
                end
                CONV: begin
                    // soc while busy is a protocol violation but never stalls the count
                    if (bus.soc) begin
                        err_r <= 1'b1;
                    end
                    if (cnt == 8'd0) begin
                        x_r     <= hold;
                        nconv_r <= nconv_r + 16'd1;
                        state   <= READY;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                default: state <= READY;
            endcase
        end
    end

    // eoc is high exactly when idle, so it falls and rises on the state edges
    assign bus.eoc   = (state == READY);
    assign bus.x     = x_r;
    assign bus.nconv = nconv_r;
    assign bus.err   = err_r;
endmodule
